// File: rtl/iadc_snapshot_if.sv
// Readback bus of the iADC snapshot buffer: address/strobe in, registered word out.
// With IADC_SNAP_OOR_EN defined the bus also carries the stored out-of-range flags.
interface iadc_snapshot_if #(
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic [63:0]       rd_data;
  logic              rd_valid;
`ifdef IADC_SNAP_OOR_EN
  logic [3:0]        rd_oor;

  modport master (output rd_addr, rd_en, input rd_data, rd_valid, rd_oor);
  modport slave  (input rd_addr, rd_en, output rd_data, rd_valid, rd_oor);
`else
  modport master (output rd_addr, rd_en, input rd_data, rd_valid);
  modport slave  (input rd_addr, rd_en, output rd_data, rd_valid);
`endif
endinterface

// File: rtl/iadc_snapshot.sv
// Snapshot capture buffer behind the iADC front end: armed trigger, block-RAM capture, readback.
// Optional feature macro IADC_SNAP_OOR_EN stores the out-of-range flags with each word.
module iadc_snapshot #(
  parameter int ADDR_W = 10
) (
  input  logic              adc_clk,
  input  logic              reset,
  input  logic [63:0]       adc_data,
  input  logic [3:0]        adc_sync,
  input  logic [3:0]        adc_outofrange,
  input  logic              arm,
  input  logic              abort,
  input  logic              trig_sel,
  input  logic [ADDR_W-1:0] cap_len,
  output logic              armed,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   wr_count,
`ifdef IADC_SNAP_OOR_EN
  output logic              oor_seen,
`endif
  iadc_snapshot_if.slave    rd
);

  localparam int DEPTH = 2 ** ADDR_W;
`ifdef IADC_SNAP_OOR_EN
  localparam int RAM_W = 68;
`else
  localparam int RAM_W = 64;
`endif

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

  state_t            state_reg, state_next;
  logic [63:0]       d_q_reg;
  logic [3:0]        s_q_reg, s_prev_reg;
  logic [ADDR_W:0]   wr_count_reg, wr_count_next;
  logic [ADDR_W-1:0] cap_len_reg, cap_len_next;
  logic              trig_sel_reg, trig_sel_next;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [RAM_W-1:0]  wr_word;
  logic [RAM_W-1:0]  rd_word_reg;
  logic              rd_valid_reg;
  logic              sync_hit;

  logic [RAM_W-1:0]  mem [DEPTH];

`ifdef IADC_SNAP_OOR_EN
  logic [3:0]        o_q_reg;
  logic              oor_seen_reg, oor_seen_next;
`else
  logic              unused_oor;
  assign unused_oor = ^adc_outofrange;
`endif

  // Single register stage on the ADC stream; every decision below uses these copies.
  always_ff @(posedge adc_clk) begin
    if (reset) begin
      d_q_reg    <= '0;
      s_q_reg    <= '0;
      s_prev_reg <= '0;
    end else begin
      d_q_reg    <= adc_data;
      s_q_reg    <= adc_sync;
      s_prev_reg <= s_q_reg;
    end
  end

`ifdef IADC_SNAP_OOR_EN
  always_ff @(posedge adc_clk) begin
    if (reset) o_q_reg <= '0;
    else       o_q_reg <= adc_outofrange;
  end
`endif

  assign sync_hit = (s_q_reg != 4'd0) && (s_prev_reg == 4'd0);

  always_ff @(posedge adc_clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      wr_count_reg <= '0;
      cap_len_reg  <= '0;
      trig_sel_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wr_count_reg <= wr_count_next;
      cap_len_reg  <= cap_len_next;
      trig_sel_reg <= trig_sel_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    wr_count_next = wr_count_reg;
    cap_len_next  = cap_len_reg;
    trig_sel_next = trig_sel_reg;
    wr_en         = 1'b0;
    wr_addr       = wr_count_reg[ADDR_W-1:0];
    // Abort wins over everything, including a pending write and a simultaneous arm.
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (arm) begin
            state_next    = ARMED;
            wr_count_next = '0;
            cap_len_next  = cap_len;
            trig_sel_next = trig_sel;
          end
        end
        ARMED: begin
          if (!trig_sel_reg || sync_hit) begin
            wr_en         = 1'b1;
            wr_addr       = '0;
            wr_count_next = (ADDR_W + 1)'(1);
            state_next    = (cap_len_reg == '0) ? DONE : CAPTURE;
          end
        end
        CAPTURE: begin
          wr_en         = 1'b1;
          wr_count_next = wr_count_reg + 1'b1;
          if (wr_addr == cap_len_reg) state_next = DONE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

`ifdef IADC_SNAP_OOR_EN
  assign wr_word = {o_q_reg, d_q_reg};

  always_comb begin
    oor_seen_next = oor_seen_reg;
    if (abort || ((state_reg == IDLE || state_reg == DONE) && arm)) oor_seen_next = 1'b0;
    else if (wr_en && (o_q_reg != 4'd0))                            oor_seen_next = 1'b1;
  end

  always_ff @(posedge adc_clk) begin
    if (reset) oor_seen_reg <= 1'b0;
    else       oor_seen_reg <= oor_seen_next;
  end

  assign oor_seen  = oor_seen_reg;
  assign rd.rd_oor = rd_word_reg[67:64];
`else
  assign wr_word = d_q_reg;
`endif

  always_ff @(posedge adc_clk) begin
    if (wr_en) mem[wr_addr] <= wr_word;
  end

  // Registered read in its own process: a same-address write this cycle is seen next time (read-first).
  always_ff @(posedge adc_clk) begin
    if (reset) begin
      rd_word_reg  <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= rd.rd_en;
      if (rd.rd_en) rd_word_reg <= mem[rd.rd_addr];
    end
  end

  assign rd.rd_data  = rd_word_reg[63:0];
  assign rd.rd_valid = rd_valid_reg;
  assign armed       = (state_reg == ARMED);
  assign busy        = (state_reg == CAPTURE);
  assign done        = (state_reg == DONE);
  assign wr_count    = wr_count_reg;

endmodule

// File: tb/tb_iadc_snapshot.sv
// Directed bench for iadc_snapshot: table of capture lengths plus hand-written
// sequences for sync trigger, abort, arm-while-busy and read-during-write.
module tb_iadc_snapshot;

  logic        adc_clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] adc_data = '0;
  logic [3:0]  adc_sync = '0;
  logic [3:0]  adc_outofrange = '0;
  logic        arm = 1'b0;
  logic        abort = 1'b0;
  logic        trig_sel = 1'b0;
  logic [9:0]  cap_len = '0;
  logic        armed, busy, done;
  logic [10:0] wr_count;
`ifdef IADC_SNAP_OOR_EN
  logic        oor_seen;
`endif

  iadc_snapshot_if #(.ADDR_W(10)) rif ();

  iadc_snapshot #(.ADDR_W(10)) dut (
    .adc_clk        (adc_clk),
    .reset          (reset),
    .adc_data       (adc_data),
    .adc_sync       (adc_sync),
    .adc_outofrange (adc_outofrange),
    .arm            (arm),
    .abort          (abort),
    .trig_sel       (trig_sel),
    .cap_len        (cap_len),
    .armed          (armed),
    .busy           (busy),
    .done           (done),
    .wr_count       (wr_count),
`ifdef IADC_SNAP_OOR_EN
    .oor_seen       (oor_seen),
`endif
    .rd             (rif)
  );

  always #5 adc_clk = ~adc_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int unsigned k = 0;
  int unsigned oor_k = 32'hFFFF_FFFF;

  typedef struct {
    logic [9:0] len;
    int         exp_wc;
    int         exp_cyc;
  } vec_t;

  function automatic logic [63:0] word(input int unsigned n);
    return {n ^ 32'h5A5A_0000, n};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock: outputs are sampled 1 time unit after the edge, then the ramp advances.
  task automatic step();
    @(posedge adc_clk);
    #1;
    k++;
    adc_data       = word(k);
    adc_outofrange = (k == oor_k) ? 4'b0001 : 4'b0000;
  endtask

  task automatic arm_capture(input logic tsel, input logic [9:0] len, output int unsigned ka);
    trig_sel = tsel;
    cap_len  = len;
    arm      = 1'b1;
    ka       = k;
    step();
    arm      = 1'b0;
  endtask

  task automatic run_to_done(output int cyc);
    cyc = 0;
    for (int n = 0; n < 3000 && !done; n++) begin
      if (armed || busy) cyc++;
      step();
    end
  endtask

  task automatic wait_wc(input int target);
    for (int n = 0; n < 200 && wr_count != 11'(target); n++) step();
    chk("wait wr_count", 64'(wr_count), 64'(target));
  endtask

  task automatic rd_chk(input string name, input int a, input logic [63:0] exp);
    rif.rd_addr = 10'(a);
    rif.rd_en   = 1'b1;
    step();
    rif.rd_en   = 1'b0;
    chk({name, " rd_valid"}, 64'(rif.rd_valid), 64'd1);
    chk(name, rif.rd_data, exp);
  endtask

  initial begin
    vec_t        vecs [4];
    int unsigned ka_hist [4];
    int unsigned ka, ka4, ka5;
    int          cyc;

    vecs[0] = '{len: 10'd15,   exp_wc: 16,   exp_cyc: 16};
    vecs[1] = '{len: 10'd1023, exp_wc: 1024, exp_cyc: 1024};
    vecs[2] = '{len: 10'd0,    exp_wc: 1,    exp_cyc: 1};
    vecs[3] = '{len: 10'd3,    exp_wc: 4,    exp_cyc: 4};

    rif.rd_addr = '0;
    rif.rd_en   = 1'b0;
    adc_data    = word(0);
    repeat (3) step();
    reset = 1'b0;
    step();
    chk("reset armed", 64'(armed), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset wr_count", 64'(wr_count), 64'd0);
    chk("reset rd_valid", 64'(rif.rd_valid), 64'd0);
    chk("reset rd_data", rif.rd_data, 64'd0);

    // Immediate-trigger captures of several lengths.
    for (int i = 0; i < 4; i++) begin
      arm_capture(1'b0, vecs[i].len, ka);
      ka_hist[i] = ka;
      chk("first cycle armed", 64'(armed), 64'd1);
      run_to_done(cyc);
      chk("capture done", 64'(done), 64'd1);
      chk("capture busy after done", 64'(busy), 64'd0);
      chk("capture wr_count", 64'(wr_count), 64'(vecs[i].exp_wc));
      chk("capture write cycles", 64'(cyc), 64'(vecs[i].exp_cyc));
      if (vecs[i].len <= 10'd15) begin
        for (int a = 0; a <= int'(vecs[i].len); a++)
          rd_chk("ramp word", a, word(ka + a));
      end else begin
        rd_chk("full addr 0", 0, word(ka));
        rd_chk("full addr last", int'(vecs[i].len), word(ka + vecs[i].len));
      end
      if (vecs[i].len == 10'd0 && i > 0)
        rd_chk("single-word addr 1 untouched", 1, word(ka_hist[i-1] + 1));
      chk("done sticky", 64'(done), 64'd1);
    end

    // Sync-edge trigger after a long quiet period.
    arm_capture(1'b1, 10'd3, ka);
    cyc = 0;
    for (int n = 0; n < 50; n++) begin
      if (armed) cyc++;
      step();
    end
    chk("sync wait armed cycles", 64'(cyc), 64'd50);
    chk("sync wait wr_count", 64'(wr_count), 64'd0);
    adc_sync = 4'b0100;
    ka = k;
    run_to_done(cyc);
    adc_sync = 4'b0000;
    chk("sync done", 64'(done), 64'd1);
    chk("sync wr_count", 64'(wr_count), 64'd4);
    rd_chk("sync addr 0", 0, word(ka));
    rd_chk("sync addr 3", 3, word(ka + 3));

    // Arm while capturing is ignored; abort at word 7 keeps the count.
    arm_capture(1'b0, 10'd20, ka4);
    wait_wc(3);
    arm = 1'b1;
    step();
    arm = 1'b0;
    chk("arm in capture busy", 64'(busy), 64'd1);
    chk("arm in capture wr_count", 64'(wr_count), 64'd4);
    wait_wc(7);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort armed", 64'(armed), 64'd0);
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    chk("abort wr_count", 64'(wr_count), 64'd7);
    rd_chk("abort addr 6", 6, word(ka4 + 6));
    arm   = 1'b1;
    abort = 1'b1;
    step();
    arm   = 1'b0;
    abort = 1'b0;
    chk("abort beats arm", 64'(armed), 64'd0);
    step();
    chk("abort beats arm later", 64'(busy), 64'd0);

    // Abort clears a sticky done without touching wr_count.
    arm_capture(1'b0, 10'd0, ka);
    run_to_done(cyc);
    chk("short done", 64'(done), 64'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort from done", 64'(done), 64'd0);
    chk("abort from done wr_count", 64'(wr_count), 64'd1);

    // Read of the address being written in the same cycle returns the old word.
    arm_capture(1'b0, 10'd7, ka5);
    wait_wc(3);
    rd_chk("read-first addr 3", 3, word(ka4 + 3));
    run_to_done(cyc);
    chk("rdw capture done", 64'(done), 64'd1);
    rd_chk("new addr 3", 3, word(ka5 + 3));
    step();
    chk("rd_valid pulse ends", 64'(rif.rd_valid), 64'd0);
    chk("rd_data holds", rif.rd_data, word(ka5 + 3));

`ifdef IADC_SNAP_OOR_EN
    // Out-of-range flag on word 5 only.
    trig_sel = 1'b0;
    cap_len  = 10'd7;
    arm      = 1'b1;
    ka       = k;
    oor_k    = ka + 5;
    step();
    arm      = 1'b0;
    run_to_done(cyc);
    chk("oor done", 64'(done), 64'd1);
    chk("oor_seen set", 64'(oor_seen), 64'd1);
    for (int a = 4; a <= 6; a++) begin
      rd_chk("oor word", a, word(ka + a));
      chk("oor flag", 64'(rif.rd_oor), (a == 5) ? 64'd1 : 64'd0);
    end
    arm_capture(1'b1, 10'd7, ka);
    chk("oor_seen cleared by arm", 64'(oor_seen), 64'd0);
    abort = 1'b1;
    step();
    abort = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
